// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared state encoding and constants for the recurrence sequencer
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_EVAL_A  = 3'd2,
        ST_SAVE_A  = 3'd3,
        ST_ISSUE_B = 3'd4,
        ST_EVAL_B  = 3'd5,
        ST_SAVE_B  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam int ALU_PASS  = 0;

    localparam int FLG_OV    = 3;
    localparam int FLG_CARRY = 2;
    localparam int FLG_NEG   = 1;
    localparam int FLG_ZERO  = 0;

endpackage

// File: rtl/ctrl_seq_iter_cnt.sv
// rtl/ctrl_seq_iter_cnt.sv - save counter with clear, increment, wrap and limit-hit detect
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear (wins over inc)
//   inc          count one completed save this cycle
//   limit        saves before completion, 0 = unlimited
//   count        registered save count, wraps modulo 2^W
//   hit          high when the increment taken this cycle reaches limit
module ctrl_seq_iter_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    logic [W-1:0] count_inc;

    assign count_inc = count + 1'b1;
    assign hit       = inc && (limit != '0) && (count_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/ctrl_recurrence_seq.sv
// rtl/ctrl_recurrence_seq.sv - two-term recurrence control sequencer for the MxN-register datapath
//
// Optional feature macro: CTRL_SEQ_ITER_LIMIT_EN (iteration counter and limit termination).
//
// Ports:
//   clk, rst_in_n                 clock, asynchronous active-low reset
//   start, abort                  level run request (IDLE only), synchronous abort
//   src_a, src_b, alu_op          operand/ALU selects, captured on start
//   dst_a, dst_b                  alternating save destinations, captured on start
//   flag_mask                     terminate mask over {fov,fcarry,fneg,fzero}
//   iter_limit                    saves before completion, 0 = unlimited
//   fov, fcarry, fneg, fzero      datapath status flags
//   selection_*                   registered datapath selects
//   writer                        registered register write enables
//   rst_out, busy, done           datapath clear request and status
//   iter_count                    completed saves
module ctrl_recurrence_seq
    import ctrl_seq_pkg::*;
#(
    parameter int N_REGS  = 4,
    parameter int SEL_W   = 8,
    parameter int ACC_IDX = 0,
    parameter int ITER_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_in_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [SEL_W-1:0]          src_a,
    input  logic [SEL_W-1:0]          src_b,
    input  logic [SEL_W-1:0]          alu_op,
    input  logic [$clog2(N_REGS)-1:0] dst_a,
    input  logic [$clog2(N_REGS)-1:0] dst_b,
    input  logic [3:0]                flag_mask,
    input  logic [ITER_W-1:0]         iter_limit,
    input  logic                      fov,
    input  logic                      fcarry,
    input  logic                      fneg,
    input  logic                      fzero,
    output logic [SEL_W-1:0]          selection_multa,
    output logic [SEL_W-1:0]          selection_multb,
    output logic [SEL_W-1:0]          selection_alu,
    output logic [SEL_W-1:0]          selection_sr,
    output logic [N_REGS-1:0]         writer,
    output logic                      rst_out,
    output logic                      busy,
    output logic                      done,
    output logic [ITER_W-1:0]         iter_count
);

    localparam int DST_W = $clog2(N_REGS);

    state_t state, state_nxt;

    logic [SEL_W-1:0]  cfg_src_a, cfg_src_b, cfg_alu;
    logic [DST_W-1:0]  cfg_dst_a, cfg_dst_b;
    logic [3:0]        cfg_mask;

    logic              capture;
    logic [SEL_W-1:0]  eff_src_a, eff_src_b, eff_alu;
    logic [3:0]        flags;
    logic              flag_hit;
    logic              in_save;
    logic              limit_hit;

    logic [SEL_W-1:0]  multa_nxt, multb_nxt, alu_nxt, sr_nxt;
    logic [N_REGS-1:0] writer_nxt;
    logic              rst_out_nxt, busy_nxt, done_nxt;

    // Accumulator is always written; when the destination is the
    // accumulator itself the two set operations collapse to one bit.
    function automatic logic [N_REGS-1:0] save_mask(input logic [DST_W-1:0] dst);
        logic [N_REGS-1:0] m;
        m          = '0;
        m[ACC_IDX] = 1'b1;
        m[dst]     = 1'b1;
        return m;
    endfunction

    assign capture = (state == ST_IDLE) && start && !abort;
    assign in_save = (state == ST_SAVE_A) || (state == ST_SAVE_B);

    // Outputs are decoded from the next state, so the first ISSUE_A cycle
    // must see the configuration being captured on this same edge.
    assign eff_src_a = capture ? src_a  : cfg_src_a;
    assign eff_src_b = capture ? src_b  : cfg_src_b;
    assign eff_alu   = capture ? alu_op : cfg_alu;

    always_comb begin
        flags            = '0;
        flags[FLG_OV]    = fov;
        flags[FLG_CARRY] = fcarry;
        flags[FLG_NEG]   = fneg;
        flags[FLG_ZERO]  = fzero;
    end

    assign flag_hit = |(cfg_mask & flags);

`ifdef CTRL_SEQ_ITER_LIMIT_EN
    logic [ITER_W-1:0] cfg_limit;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cfg_limit <= '0;
        end else if (capture) begin
            cfg_limit <= iter_limit;
        end
    end

    // Clearing on every entry to IDLE keeps iter_count at 0 there while
    // leaving the final count visible throughout DONE.
    ctrl_seq_iter_cnt #(
        .W     (ITER_W)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_in_n),
        .clr   (capture || (state_nxt == ST_IDLE)),
        .inc   (in_save),
        .limit (cfg_limit),
        .count (iter_count),
        .hit   (limit_hit)
    );
`else
    logic unused_limit;

    assign unused_limit = ^iter_limit;
    assign iter_count   = '0;
    assign limit_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cfg_src_a <= '0;
            cfg_src_b <= '0;
            cfg_alu   <= '0;
            cfg_dst_a <= '0;
            cfg_dst_b <= '0;
            cfg_mask  <= '0;
        end else if (capture) begin
            cfg_src_a <= src_a;
            cfg_src_b <= src_b;
            cfg_alu   <= alu_op;
            cfg_dst_a <= dst_a;
            cfg_dst_b <= dst_b;
            cfg_mask  <= flag_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_ISSUE_A;
            ST_ISSUE_A: state_nxt = ST_EVAL_A;
            ST_EVAL_A:  state_nxt = flag_hit ? ST_DONE : ST_SAVE_A;
            ST_SAVE_A:  state_nxt = limit_hit ? ST_DONE : ST_ISSUE_B;
            ST_ISSUE_B: state_nxt = ST_EVAL_B;
            ST_EVAL_B:  state_nxt = flag_hit ? ST_DONE : ST_SAVE_B;
            ST_SAVE_B:  state_nxt = limit_hit ? ST_DONE : ST_ISSUE_A;
            ST_DONE:    if (!start) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // Abort overrides flag and limit termination.
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        multa_nxt   = '0;
        multb_nxt   = '0;
        alu_nxt     = '0;
        sr_nxt      = '0;
        writer_nxt  = '0;
        rst_out_nxt = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        case (state_nxt)
            ST_ISSUE_A, ST_EVAL_A, ST_ISSUE_B, ST_EVAL_B: begin
                multa_nxt = eff_src_a;
                multb_nxt = eff_src_b;
                alu_nxt   = eff_alu;
                busy_nxt  = 1'b1;
            end
            ST_SAVE_A: begin
                multa_nxt  = cfg_src_a;
                multb_nxt  = cfg_src_b;
                alu_nxt    = SEL_W'(ALU_PASS);
                writer_nxt = save_mask(cfg_dst_a);
                busy_nxt   = 1'b1;
            end
            ST_SAVE_B: begin
                multa_nxt  = cfg_src_a;
                multb_nxt  = cfg_src_b;
                alu_nxt    = SEL_W'(ALU_PASS);
                writer_nxt = save_mask(cfg_dst_b);
                busy_nxt   = 1'b1;
            end
            ST_DONE: begin
                rst_out_nxt = 1'b1;
                done_nxt    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            selection_multa <= '0;
            selection_multb <= '0;
            selection_alu   <= '0;
            selection_sr    <= '0;
            writer          <= '0;
            rst_out         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            selection_multa <= multa_nxt;
            selection_multb <= multb_nxt;
            selection_alu   <= alu_nxt;
            selection_sr    <= sr_nxt;
            writer          <= writer_nxt;
            rst_out         <= rst_out_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ctrl_recurrence_seq.sv
// tb/tb_ctrl_recurrence_seq.sv - directed self-checking bench for ctrl_recurrence_seq
module tb_ctrl_recurrence_seq;

    logic       clk;
    logic       rst_in_n;
    logic       start;
    logic       abort;
    logic [7:0] src_a, src_b, alu_op;
    logic [1:0] dst_a, dst_b;
    logic [3:0] flag_mask;
    logic [7:0] iter_limit;
    logic       fov, fcarry, fneg, fzero;
    logic [7:0] selection_multa, selection_multb, selection_alu, selection_sr;
    logic [3:0] writer;
    logic       rst_out, busy, done;
    logic [7:0] iter_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CTRL_SEQ_ITER_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    ctrl_recurrence_seq #(
        .N_REGS  (4),
        .SEL_W   (8),
        .ACC_IDX (0),
        .ITER_W  (8)
    ) dut (
        .clk             (clk),
        .rst_in_n        (rst_in_n),
        .start           (start),
        .abort           (abort),
        .src_a           (src_a),
        .src_b           (src_b),
        .alu_op          (alu_op),
        .dst_a           (dst_a),
        .dst_b           (dst_b),
        .flag_mask       (flag_mask),
        .iter_limit      (iter_limit),
        .fov             (fov),
        .fcarry          (fcarry),
        .fneg            (fneg),
        .fzero           (fzero),
        .selection_multa (selection_multa),
        .selection_multb (selection_multb),
        .selection_alu   (selection_alu),
        .selection_sr    (selection_sr),
        .writer          (writer),
        .rst_out         (rst_out),
        .busy            (busy),
        .done            (done),
        .iter_count      (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_in_n   = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        src_a      = 8'd2;
        src_b      = 8'd3;
        alu_op     = 8'd1;
        dst_a      = 2'd2;
        dst_b      = 2'd3;
        flag_mask  = 4'b0000;
        iter_limit = 8'd0;
        {fov, fcarry, fneg, fzero} = 4'b0000;

        // Reset state
        step();
        step();
        check("rst_writer", writer, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rst_out", rst_out, 0);
        check("rst_multa", selection_multa, 0);
        check("rst_iter", iter_count, 0);
        rst_in_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Fibonacci run terminated by fcarry in the 5th EVAL
        flag_mask = 4'b0100;
        start = 1'b1;
        step();
        start = 1'b0;
        check("fib_issue_multa", selection_multa, 2);
        check("fib_issue_multb", selection_multb, 3);
        check("fib_issue_alu", selection_alu, 1);
        check("fib_issue_sr", selection_sr, 0);
        check("fib_issue_writer", writer, 0);
        check("fib_issue_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fib_eval_writer", writer, 0);
            step();
            check("fib_save_writer", writer, (i % 2 == 0) ? 32'h5 : 32'h9);
            check("fib_save_alu", selection_alu, 0);
            check("fib_save_multa", selection_multa, 2);
            check("fib_save_iter", iter_count, LIM_EN ? i : 0);
            step();
        end
        step();
        check("fib_eval5_busy", busy, 1);
        fcarry = 1'b1;
        step();
        fcarry = 1'b0;
        check("fib_done", done, 1);
        check("fib_rst_out", rst_out, 1);
        check("fib_done_writer", writer, 0);
        check("fib_done_multa", selection_multa, 0);
        check("fib_done_busy", busy, 0);
        check("fib_done_iter", iter_count, LIM_EN ? 4 : 0);
        step();
        check("fib_idle_done", done, 0);
        check("fib_idle_iter", iter_count, 0);

        // Iteration limit of 3 saves
        flag_mask  = 4'b0000;
        iter_limit = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 2) check("lim_w1", writer, 5);
            if (c == 5) check("lim_w2", writer, 9);
            if (c == 8) begin
                check("lim_w3", writer, 5);
                check("lim_pre_done", done, 0);
            end
        end
`ifdef CTRL_SEQ_ITER_LIMIT_EN
        check("lim_done", done, 1);
        check("lim_writer", writer, 0);
        check("lim_iter", iter_count, 3);
        step();
`else
        check("nolim_done", done, 0);
        check("nolim_busy", busy, 1);
        check("nolim_iter", iter_count, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif
        check("lim_idle_busy", busy, 0);
        iter_limit = 8'd0;

        // Abort and flag in the same EVAL_B cycle
        flag_mask = 4'b0100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        check("ab_evalb_busy", busy, 1);
        abort  = 1'b1;
        fcarry = 1'b1;
        step();
        abort  = 1'b0;
        fcarry = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_writer", writer, 0);
        check("ab_multa", selection_multa, 0);
        step();
        check("ab_done_after", done, 0);

        // Handshake: start held through DONE, then dropped and re-raised
        start = 1'b1;
        step();
        step();
        step();
        step();
        step();
        fcarry = 1'b1;
        step();
        fcarry = 1'b0;
        check("hs_done", done, 1);
        check("hs_iter", iter_count, LIM_EN ? 1 : 0);
        step();
        check("hs_hold1", done, 1);
        step();
        check("hs_hold2", done, 1);
        start = 1'b0;
        step();
        check("hs_drop_done", done, 0);
        check("hs_drop_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("hs_rerun_busy", busy, 1);
        check("hs_rerun_iter", iter_count, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Reset asserted during SAVE_A
        flag_mask = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mr_save_writer", writer, 5);
        #1;
        rst_in_n = 1'b0;
        #1;
        check("mr_async_writer", writer, 0);
        check("mr_async_busy", busy, 0);
        check("mr_async_multa", selection_multa, 0);
        step();
        rst_in_n = 1'b1;
        step();
        check("mr_idle_busy", busy, 0);
        check("mr_idle_writer", writer, 0);

        // fzero only outside EVAL cycles must not terminate the run
        flag_mask  = 4'b0001;
        iter_limit = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        fzero = 1'b1;
        step();
        fzero = 1'b0;
        step();
        check("fi_sa_writer", writer, 5);
        fzero = 1'b1;
        step();
        check("fi_ib_busy", busy, 1);
        step();
        fzero = 1'b0;
        step();
        check("fi_sb_writer", writer, 9);
        fzero = 1'b1;
        step();
        fzero = 1'b0;
`ifdef CTRL_SEQ_ITER_LIMIT_EN
        check("fi_done", done, 1);
        check("fi_iter", iter_count, 2);
`else
        check("fi_done", done, 0);
        check("fi_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
